// File: rtl/blink_pkg.sv
// blink_pkg: shared widths and loader state encoding for the Blink-128 tweakey path
package blink_pkg;
  localparam int WORD_W = 32;
  localparam int KEY_W = 766;
  localparam int TWEAK_W = 256;
  localparam int KEY_WORDS = (KEY_W + WORD_W - 1) / WORD_W;
  localparam int TWEAK_WORDS = TWEAK_W / WORD_W;
  localparam int KEY_LAST_BITS = KEY_W - (KEY_WORDS - 1) * WORD_W;
  typedef enum logic [1:0] {IDLE, LOAD_KEY, LOAD_TWEAK, HOLD} ldr_state_t;
endpackage

// File: rtl/tweakey_loader.sv
// tweakey_loader: deserialises a word stream into the hash key and tweak registers for the tweakey generator
module tweakey_loader
  import blink_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_load_key,
  input  logic               key_clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KEY_W-1:0]   key_out,
  output logic [TWEAK_W-1:0] tweak_out,
  output logic               key_loaded
);
  ldr_state_t state;
  logic [4:0] wcnt;
  logic beat, cmd_acc, clr, key_last, tweak_last;
  assign cmd_ready = state == IDLE;
  assign in_ready = state == LOAD_KEY || state == LOAD_TWEAK;
  assign out_valid = state == HOLD;
  assign beat = in_valid && in_ready;
  assign cmd_acc = cmd_valid && cmd_ready;
  assign clr = key_clear && cmd_ready && !cmd_valid;
  assign key_last = wcnt == 5'(KEY_WORDS - 1);
  assign tweak_last = wcnt == 5'(TWEAK_WORDS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      key_loaded <= 1'b0;
    end else if (cmd_acc) begin
      state <= (cmd_load_key || !key_loaded) ? LOAD_KEY : LOAD_TWEAK;
      key_loaded <= key_loaded && !cmd_load_key;
      wcnt <= '0;
    end else if (clr) key_loaded <= 1'b0;
    else if (out_valid && out_ready) state <= IDLE;
    else if (beat) begin
      wcnt <= ((state == LOAD_KEY) ? key_last : tweak_last) ? 5'd0 : wcnt + 5'd1;
      if (state == LOAD_KEY && key_last) begin
        key_loaded <= 1'b1;
        state <= LOAD_TWEAK;
      end
      if (state == LOAD_TWEAK && tweak_last) state <= HOLD;
    end
  // the top key word is short; its upper input bits are dropped
  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
    localparam int W = (i == KEY_WORDS - 1) ? KEY_LAST_BITS : WORD_W;
    always_ff @(posedge clk or posedge rst)
      if (rst) key_out[i*WORD_W +: W] <= '0;
      else if (clr) key_out[i*WORD_W +: W] <= '0;
      else if (beat && state == LOAD_KEY && wcnt == 5'(i)) key_out[i*WORD_W +: W] <= in_data[W-1:0];
  end
  for (genvar i = 0; i < TWEAK_WORDS; i++) begin : g_tweak
    always_ff @(posedge clk or posedge rst)
      if (rst) tweak_out[i*WORD_W +: WORD_W] <= '0;
      else if (beat && state == LOAD_TWEAK && wcnt == 5'(i)) tweak_out[i*WORD_W +: WORD_W] <= in_data;
  end
endmodule

// File: tb/tb_tweakey_loader.sv
// tb_tweakey_loader: directed scenarios for the tweakey loader with a word-layout reference model
module tb_tweakey_loader;
  import blink_pkg::*;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_load_key = 0, key_clear = 0, in_valid = 0, out_ready = 0;
  logic cmd_ready, in_ready, out_valid, key_loaded;
  logic [WORD_W-1:0] in_data = '0;
  logic [KEY_W-1:0] key_out, key_m, key_prev;
  logic [TWEAK_W-1:0] tweak_out, tweak_m, tweak_prev;
  logic [WORD_W-1:0] seq [32];
  int checks = 0, failures = 0, lat;

  tweakey_loader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load_key(cmd_load_key), .key_clear(key_clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .key_out(key_out), .tweak_out(tweak_out), .key_loaded(key_loaded)
  );

  always #5 clk = ~clk;

  task automatic set_full(input logic [31:0] kbase, input logic [31:0] tbase, input bit rnd);
    logic [KEY_WORDS*WORD_W-1:0] t;
    for (int k = 0; k < 24; k++) seq[k] = rnd ? 32'($urandom) : (k == 23 ? 32'hFFFF_FFFF : kbase + k);
    for (int k = 0; k < 8; k++) seq[24+k] = rnd ? 32'($urandom) : tbase + k;
    t = '0;
    for (int k = 0; k < 24; k++) t[k*32 +: 32] = seq[k];
    key_m = t[KEY_W-1:0];
    for (int k = 0; k < 8; k++) tweak_m[k*32 +: 32] = seq[24+k];
  endtask

  task automatic do_frame(input bit lk, input int n, input bit gaps, input bit kc, output int l);
    bit go, acc;
    int i;
    cmd_valid = 1; cmd_load_key = lk; key_clear = kc;
    @(posedge clk); #1;
    cmd_valid = 0; key_clear = 0;
    l = 0; i = 0;
    while (!out_valid && l < 300) begin
      go = i < n && (!gaps || $urandom_range(1, 0) == 1);
      in_valid = go; in_data = seq[i < 32 ? i : 0];
      acc = go && in_ready;
      @(posedge clk); #1;
      l++;
      if (acc) i++;
    end
    in_valid = 0;
  endtask

  task automatic take_frame(input int stall);
    for (int s = 0; s < stall; s++) begin
      checks++;
      if (!out_valid || in_ready || cmd_ready || key_out !== key_m || tweak_out !== tweak_m) begin
        failures++;
        $display("FAIL hold_stable cycle %0d: out_valid=%b in_ready=%b cmd_ready=%b key_ok=%b tweak_ok=%b, required 1 0 0 1 1",
                 s, out_valid, in_ready, cmd_ready, key_out === key_m, tweak_out === tweak_m);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL hold_flags: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL release: out_valid=%b cmd_ready=%b, required 0 1", out_valid, cmd_ready);
    end
  endtask

  task automatic check_model(input string name);
    checks++;
    if (key_out !== key_m) begin failures++; $display("FAIL %s_key: got %h required %h", name, key_out[255:0], key_m[255:0]); end
    checks++;
    if (tweak_out !== tweak_m) begin failures++; $display("FAIL %s_tweak: got %h required %h", name, tweak_out, tweak_m); end
  endtask

  task automatic check_lat(input string name, input int exp);
    checks++;
    if (lat !== exp) begin failures++; $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, exp); end
  endtask

  task automatic test_reset;
    rst = 1; #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 0 || key_loaded !== 0 || key_out !== '0 || tweak_out !== '0) begin
      failures++; $display("FAIL reset_values: out_valid=%b in_ready=%b key_loaded=%b key_zero=%b tweak_zero=%b, required 0 0 0 1 1",
                           out_valid, in_ready, key_loaded, key_out === '0, tweak_out === '0);
    end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1 || in_ready !== 0 || out_valid !== 0) begin
      failures++; $display("FAIL reset_release: cmd_ready=%b in_ready=%b out_valid=%b, required 1 0 0", cmd_ready, in_ready, out_valid);
    end
  endtask

  task automatic test_full_load;
    set_full(32'h0, 32'hA5A5_0000, 0);
    do_frame(1, 32, 0, 0, lat);
    check_lat("full", 32);
    checks++;
    if (key_out[765:736] !== 30'h3FFF_FFFF) begin failures++; $display("FAIL full_key_top: got %h required 3fffffff", key_out[765:736]); end
    checks++;
    if (key_out[31:0] !== 32'h0) begin failures++; $display("FAIL full_key_low: got %h required 00000000", key_out[31:0]); end
    checks++;
    if (tweak_out[255:224] !== 32'hA5A5_0007) begin failures++; $display("FAIL full_tweak_top: got %h required a5a50007", tweak_out[255:224]); end
    checks++;
    if (key_loaded !== 1) begin failures++; $display("FAIL full_key_loaded: got %b required 1", key_loaded); end
    check_model("full");
    take_frame(2);
  endtask

  task automatic test_tweak_only;
    key_prev = key_out;
    for (int k = 0; k < 8; k++) seq[k] = 32'h1111_1111;
    tweak_m = {8{32'h1111_1111}};
    do_frame(0, 8, 0, 0, lat);
    check_lat("tweak_only", 8);
    checks++;
    if (key_out !== key_prev) begin failures++; $display("FAIL tweak_only_key_kept: got %h required %h", key_out[255:0], key_prev[255:0]); end
    checks++;
    if (tweak_out !== tweak_m) begin failures++; $display("FAIL tweak_only_tweak: got %h required %h", tweak_out, tweak_m); end
    take_frame(0);
  endtask

  task automatic test_key_clear;
    tweak_prev = tweak_out;
    key_clear = 1;
    @(posedge clk); #1 key_clear = 0;
    checks++;
    if (key_loaded !== 0 || key_out !== '0 || tweak_out !== tweak_prev) begin
      failures++; $display("FAIL key_clear: key_loaded=%b key_zero=%b tweak_kept=%b, required 0 1 1", key_loaded, key_out === '0, tweak_out === tweak_prev);
    end
    set_full(32'h0, 32'h0, 1);
    do_frame(1, 32, 0, 0, lat);
    check_lat("reload", 32);
    take_frame(0);
    for (int k = 0; k < 8; k++) begin seq[k] = 32'hC0DE_0000 + k; tweak_m[k*32 +: 32] = 32'hC0DE_0000 + k; end
    do_frame(0, 8, 0, 1, lat);
    check_lat("clear_with_cmd", 8);
    checks++;
    if (key_loaded !== 1) begin failures++; $display("FAIL clear_with_cmd_loaded: got %b required 1", key_loaded); end
    check_model("clear_with_cmd");
    take_frame(0);
  endtask

  task automatic test_promote;
    rst = 1; #1;
    @(posedge clk); #1 rst = 0;
    set_full(32'h1000_0000, 32'h2000_0000, 0);
    do_frame(0, 32, 0, 0, lat);
    check_lat("promote", 32);
    checks++;
    if (key_out[255:0] !== {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                            32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000}) begin
      failures++; $display("FAIL promote_first8_in_key: got %h", key_out[255:0]);
    end
    checks++;
    if (key_loaded !== 1) begin failures++; $display("FAIL promote_key_loaded: got %b required 1", key_loaded); end
    check_model("promote");
    take_frame(0);
  endtask

  task automatic test_random_stall;
    set_full(32'h0, 32'h0, 1);
    do_frame(1, 32, 1, 0, lat);
    checks++;
    if (lat < 32 || lat >= 300) begin failures++; $display("FAIL stall_latency: got %0d edges, required 32..299", lat); end
    check_model("stall");
    take_frame(20);
  endtask

  task automatic test_reset_midload;
    set_full(32'h0, 32'hA5A5_0000, 0);
    cmd_valid = 1; cmd_load_key = 1;
    @(posedge clk); #1 cmd_valid = 0;
    for (int k = 0; k <= 10; k++) begin
      in_valid = 1; in_data = seq[k];
      @(posedge clk); #1;
    end
    in_valid = 0;
    checks++;
    if (key_out[351:320] !== 32'h0000_000A || key_loaded !== 0) begin
      failures++; $display("FAIL midload_partial: word10=%h key_loaded=%b, required 0000000a 0", key_out[351:320], key_loaded);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (key_out !== '0 || tweak_out !== '0 || key_loaded !== 0 || in_ready !== 0 || out_valid !== 0) begin
      failures++; $display("FAIL midload_async_reset: key_zero=%b tweak_zero=%b key_loaded=%b in_ready=%b out_valid=%b, required 1 1 0 0 0",
                           key_out === '0, tweak_out === '0, key_loaded, in_ready, out_valid);
    end
    @(posedge clk); #1 rst = 0;
    set_full(32'h5500_0000, 32'h6600_0000, 0);
    do_frame(1, 32, 0, 0, lat);
    check_lat("after_reset", 32);
    check_model("after_reset");
    take_frame(0);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_tweak_only();
    test_key_clear();
    test_promote();
    test_random_stall();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
